// File: rtl/seq_divider_16bit_if.sv
// Handshake and operand/result bundle for the sequential 16-bit divider.
// The slave side is the divider; the master side is the requester.
interface seq_divider_16bit_if;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider_16bit.sv
// Unsigned 16-bit restoring divider: one quotient bit per clock over 16 RUN
// cycles, trial subtraction through a two-level carry-lookahead adder.
module seq_divider_16bit #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_divider_16bit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Two-level CLA: 4-bit groups feed a group-level lookahead; returns {c16, sum}.
  function automatic logic [16:0] cla16(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    logic [15:0] g, p, c;
    logic [3:0]  gg, pg;
    logic [4:0]  cg;
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
    cg[0] = cin;
    cg[1] = gg[0] | (pg[0] & cin);
    cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & cin);
    cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = cg[k];
      c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
    end
    return {cg[4], p ^ c};
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH:0]     r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     r_shift_s;
  logic [16:0]        trial_s;
  logic               nonneg_s;
  logic [WIDTH:0]     r_next_s;
  logic [WIDTH-1:0]   q_next_s;

  // R[16] keeps the bit shifted out of R[15] so maximum operands cannot overflow.
  always_comb begin
    r_shift_s = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial_s   = cla16(r_shift_s[15:0], ~d_q, 1'b1);
    nonneg_s  = r_shift_s[WIDTH] | trial_s[16];
    r_next_s  = nonneg_s ? {1'b0, trial_s[15:0]} : r_shift_s;
    q_next_s  = {q_q[WIDTH-2:0], nonneg_s};
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          d_d = bus.divisor;
          if (bus.divisor == 16'd0) begin
            state_d = S_DONE;
            quo_d   = 16'hFFFF;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            r_d     = 17'd0;
            q_d     = bus.dividend;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        r_d   = r_next_s;
        q_d   = q_next_s;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_DONE;
          quo_d   = q_next_s;
          rem_d   = r_next_s[WIDTH-1:0];
          dbz_d   = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= 17'd0;
      q_q     <= 16'd0;
      d_q     <= 16'd0;
      cnt_q   <= 4'd0;
      quo_q   <= 16'd0;
      rem_q   <= 16'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Scoreboard bench for seq_divider_16bit: directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_divider_16bit;

  logic clk;
  logic rst;
  seq_divider_16bit_if bus ();

  seq_divider_16bit #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dvd;
    logic [15:0] dvs;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: counts busy cycles and checks every completed result against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy) busy_cnt++;
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("quotient", {16'd0, bus.quotient}, {16'd0, e.q});
        check("remainder", {16'd0, bus.remainder}, {16'd0, e.r});
        check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
        check("done_latency", cyc, e.cyc);
        check("busy_cycles", busy_cnt, e.dbz ? 32'd0 : 32'd16);
        if (!e.dbz) begin
          check("invariant", {16'd0, bus.quotient} * {16'd0, e.dvs} + {16'd0, bus.remainder},
                {16'd0, e.dvd});
          check("rem_lt_div", {31'd0, bus.remainder < e.dvs}, 32'd1);
        end
      end
      busy_cnt = 0;
    end else if (!bus.busy) begin
      busy_cnt = 0;
    end
  end

  // Drives one start pulse at the current negedge; push_exp=0 for abandoned ops.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input bit push_exp);
    exp_t e;
    e.dvd = a;
    e.dvs = b;
    e.q   = eq;
    e.r   = er;
    e.dbz = (b == 16'd0);
    e.cyc = cyc + ((b == 16'd0) ? 1 : 17);
    if (push_exp) sb.push_back(e);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout_idle", sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) check("timeout_done", 32'd0, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a, b;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 16'd0;
    bus.divisor  = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_quotient", {16'd0, bus.quotient}, 32'd0);
    check("reset_remainder", {16'd0, bus.remainder}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);

    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b1);
    wait_idle();
    issue(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b1);
    wait_idle();
    issue(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b1);
    wait_idle();
    issue(16'd3, 16'd10, 16'd0, 16'd3, 1'b1);
    wait_idle();
    issue(16'h8000, 16'h8001, 16'd0, 16'h8000, 1'b1);
    wait_idle();

    issue(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
    wait_idle();
    issue(16'd9, 16'd4, 16'd2, 16'd1, 1'b1);
    wait_idle();

    // Start pulse in RUN cycle 6 must be ignored.
    issue(16'd1000, 16'd3, 16'd333, 16'd1, 1'b1);
    repeat (5) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd50;
    bus.divisor  = 16'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Start held during DONE is accepted back-to-back.
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b1);
    wait_done();
    issue(16'd50, 16'd5, 16'd10, 16'd0, 1'b1);
    wait_idle();

    // Reset in RUN cycle 9 abandons the op without a done pulse.
    issue(16'd60000, 16'd7, 16'd8571, 16'd3, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_quotient", {16'd0, bus.quotient}, 32'd0);
    check("midrst_remainder", {16'd0, bus.remainder}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    repeat (20) @(negedge clk);
    issue(16'd60000, 16'd7, 16'd8571, 16'd3, 1'b1);
    wait_idle();

    for (int i = 0; i < 200; i++) begin
      a = 16'($urandom);
      b = (i % 2 == 0) ? 16'($urandom_range(1, 65535)) : 16'($urandom_range(1, 300));
      issue(a, b, a / b, a % b, 1'b1);
      wait_idle();
    end

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
